// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, branch redirect and decode handshake.
// master is the fetch unit's view; slave is the surrounding environment.
interface fetch_unit_if;
  logic [31:0] rom_address;
  logic        rom_write_enable;
  logic [31:0] rom_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output rom_address,
    output rom_write_enable,
    input  rom_data,
    input  branch_valid,
    input  branch_target,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  rom_address,
    input  rom_write_enable,
    output rom_data,
    output branch_valid,
    output branch_target,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives word addresses into a synchronous ROM, captures
// the returned words with their PCs in a small FIFO and hands them to decode.
// A branch flushes the FIFO, kills the in-flight read and issues the target at once.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0800_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic         clock,
  input logic         reset,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0]     fetch_pc;
  logic [31:0]     inflight_pc;
  logic            inflight;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_data [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  logic [CntW:0]   occupancy;
  logic            unused_target_bits;

  // Address mux, handshake decode and read-issue credit check.
  always_comb begin
    bus.rom_address      = bus.branch_valid ? {bus.branch_target[31:2], 2'b00} : fetch_pc;
    bus.rom_write_enable = 1'b0;
    bus.instr_valid      = (count != '0);
    bus.instr_data       = fifo_data[head];
    bus.instr_pc         = fifo_pc[head];
    pop                  = bus.instr_valid & bus.instr_ready & ~bus.branch_valid;
    // A killed read never lands, so a branch cycle never pushes.
    push                 = inflight & ~bus.branch_valid;
    // Entries held plus the read still returning must leave room, net of this cycle's pop.
    occupancy            = {1'b0, count} + (CntW + 1)'(inflight) - (CntW + 1)'(pop);
    issue                = ~reset & (bus.branch_valid | (occupancy < DepthCnt));
  end

  assign unused_target_bits = ^bus.branch_target[1:0];

  // Fetch PC, in-flight tracking and FIFO state.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (issue) begin
        fetch_pc    <= bus.rom_address + 32'd4;
        inflight_pc <= bus.rom_address;
      end
      inflight <= issue;
      if (bus.branch_valid) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          fifo_pc[tail]   <= inflight_pc;
          fifo_data[tail] <= bus.rom_data;
          tail            <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        count <= count + CntW'(push) - CntW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, scoreboard of expected deliveries,
// and one task per scenario.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0800_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // ROM model: synchronous read, mem[A] = A ^ A5A5A5A5.
  always @(posedge clock) bus.rom_data <= bus.rom_address ^ 32'hA5A5A5A5;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: a, data: rom_word(a)});
      a = a + 32'd4;
    end
  endtask

  // Holds ready until every expected word is accepted, then drops it.
  task automatic drain(input int budget, output bit timed_out);
    int n;
    n = 0;
    bus.instr_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    bus.instr_ready = 1'b0;
    timed_out = (sb.size() != 0);
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.branch_valid = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted head must match the next expected entry.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1 && bus.branch_valid === 1'b0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL deliver: got pc %h data %h, required no delivery", bus.instr_pc,
                 bus.instr_data);
      end else begin
        e = sb.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr_data !== e.data) begin
          miscompares++;
          $display("FAIL deliver: got pc %h data %h, required pc %h data %h", bus.instr_pc,
                   bus.instr_data, e.pc, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    bit to;
    vectors++;
    if (bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 || bus.instr_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h pc=%h, required v=0 d=0 pc=0",
               bus.instr_valid, bus.instr_data, bus.instr_pc);
    end
    vectors++;
    if (bus.rom_address !== ResetPc || bus.rom_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rom: got addr=%h we=%b, required addr=%h we=0", bus.rom_address,
               bus.rom_write_enable, ResetPc);
    end
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    push_seq(ResetPc, 3);
    step();
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_early: got valid=%b, required 0", bus.instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ResetPc + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_%0d: got valid=%b pc=%h, required valid=1 pc=%h", i,
                 bus.instr_valid, bus.instr_pc, ResetPc + 32'(4 * i));
      end
    end
    drain(4, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL stream_drain: got timeout, required all words delivered");
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ResetPc ||
          bus.instr_data !== 32'hADA5A5A5 || bus.rom_address !== 32'h0800_0008) begin
        miscompares++;
        $display("FAIL stall_%0d: got v=%b pc=%h d=%h addr=%h, required v=1 pc=%h d=ADA5A5A5 addr=08000008",
                 i, bus.instr_valid, bus.instr_pc, bus.instr_data, bus.rom_address, ResetPc);
      end
    end
    push_seq(ResetPc, 3);
    bus.instr_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      vectors++;
      if (bus.instr_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_gap: got valid=%b, required 1", bus.instr_valid);
      end
      step();
      n++;
    end
    bus.instr_ready = 1'b0;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d undelivered, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_branch_full();
    bit to;
    do_reset();
    step();
    step();
    step();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'h0800_0103;
    sb.delete();
    #1;
    vectors++;
    if (bus.rom_address !== 32'h0800_0100) begin
      miscompares++;
      $display("FAIL branch_addr: got %h, required 08000100", bus.rom_address);
    end
    step();
    bus.branch_valid = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL branch_flush: got valid=%b, required 0", bus.instr_valid);
    end
    step();
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0800_0100 ||
        bus.instr_data !== 32'hADA5A4A5) begin
      miscompares++;
      $display("FAIL branch_target: got v=%b pc=%h d=%h, required v=1 pc=08000100 d=ADA5A4A5",
               bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
    push_seq(32'h0800_0100, 3);
    drain(8, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL branch_drain: got timeout, required all words delivered");
    end
  endtask

  task automatic test_branch_ready();
    bit to;
    do_reset();
    step();
    step();
    bus.instr_ready = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'h0800_0200;
    sb.delete();
    push_seq(32'h0800_0200, 2);
    step();
    bus.branch_valid = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL br_ready_flush: got valid=%b, required 0", bus.instr_valid);
    end
    step();
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0800_0200) begin
      miscompares++;
      $display("FAIL br_ready_next: got v=%b pc=%h, required v=1 pc=08000200",
               bus.instr_valid, bus.instr_pc);
    end
    drain(8, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL br_ready_drain: got timeout, required all words delivered");
    end
  endtask

  task automatic test_held_branch();
    bit to;
    do_reset();
    step();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'h0800_0300;
    sb.delete();
    push_seq(32'h0800_0300, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.rom_address !== 32'h0800_0300) begin
        miscompares++;
        $display("FAIL held_addr_%0d: got %h, required 08000300", i, bus.rom_address);
      end
      step();
      vectors++;
      if (bus.instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL held_empty_%0d: got valid=%b, required 0", i, bus.instr_valid);
      end
    end
    bus.branch_valid = 1'b0;
    step();
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0800_0300) begin
      miscompares++;
      $display("FAIL held_release: got v=%b pc=%h, required v=1 pc=08000300",
               bus.instr_valid, bus.instr_pc);
    end
    drain(8, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL held_drain: got timeout, required all words delivered");
    end
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    step();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'hFFFF_FFF8;
    sb.delete();
    push_seq(32'hFFFF_FFF8, 4);
    step();
    bus.branch_valid = 1'b0;
    drain(12, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL wrap_drain: got timeout, required all words delivered");
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    step();
    step();
    step();
    push_seq(ResetPc, 1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    step();
    vectors++;
    if (bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0 || bus.instr_pc !== 32'h0 ||
        bus.rom_address !== ResetPc) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b d=%h pc=%h addr=%h, required v=0 d=0 pc=0 addr=%h",
               bus.instr_valid, bus.instr_data, bus.instr_pc, bus.rom_address, ResetPc);
    end
    reset = 1'b0;
    sb.delete();
    push_seq(ResetPc, 2);
    step();
    vectors++;
    if (bus.instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_restart_early: got valid=%b, required 0", bus.instr_valid);
    end
    step();
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ResetPc) begin
      miscompares++;
      $display("FAIL mid_restart: got v=%b pc=%h, required v=1 pc=%h", bus.instr_valid,
               bus.instr_pc, ResetPc);
    end
    drain(8, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL mid_drain: got timeout, required all words delivered");
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.branch_valid = 1'b0;
    bus.branch_target = 32'h0;
    bus.instr_ready = 1'b0;
    step();
    step();
    test_reset();
    test_backpressure();
    test_branch_full();
    test_branch_ready();
    test_held_branch();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

endmodule
